// File: rtl/seg_memory_writeback_if.sv
// Bundle of the EX->MEM inputs and MEM/WB outputs of the memory/writeback segment.
// The master drives the pipeline inputs; the slave is the segment itself.
interface seg_memory_writeback_if #(
  parameter int LEN        = 32,
  parameter int NB_ADDR    = 5,
  parameter int NB_CTRL_M  = 9,
  parameter int NB_CTRL_WB = 2
);
  logic [LEN-1:0]        i_alu_result;
  logic [LEN-1:0]        i_store_data;
  logic [NB_ADDR-1:0]    i_write_reg;
  logic                  i_zero;
  logic [LEN-1:0]        i_branch_target;
  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus;
  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus;
  logic                  o_pc_src;
  logic [LEN-1:0]        o_branch_target;
  logic [NB_ADDR-1:0]    o_write_reg;
  logic [LEN-1:0]        o_write_data;
  logic                  o_RegWrite;
  logic                  o_misaligned;

  modport master (
    output i_alu_result, i_store_data, i_write_reg, i_zero, i_branch_target,
           i_ctrl_mem_bus, i_ctrl_wb_bus,
    input  o_pc_src, o_branch_target, o_write_reg, o_write_data, o_RegWrite,
           o_misaligned
  );

  modport slave (
    input  i_alu_result, i_store_data, i_write_reg, i_zero, i_branch_target,
           i_ctrl_mem_bus, i_ctrl_wb_bus,
    output o_pc_src, o_branch_target, o_write_reg, o_write_data, o_RegWrite,
           o_misaligned
  );
endinterface

// File: rtl/seg_memory_writeback.sv
// MEM and WB pipeline segment: branch decision, byte-addressable data memory with
// sub-word stores, synchronous loads with alignment checking, and the MEM/WB register.
module seg_memory_writeback #(
  parameter int LEN          = 32,
  parameter int NB_ADDR      = 5,
  parameter int NB_CTRL_M    = 9,
  parameter int NB_CTRL_WB   = 2,
  parameter int NB_DMEM_ADDR = 10
) (
  input logic                  i_clk,
  input logic                  i_rst,
  seg_memory_writeback_if.slave bus
);

  localparam int DEPTH  = 1 << NB_DMEM_ADDR;
  localparam int NLANES = LEN / 8;

  function automatic logic is_misaligned(input logic half, input logic word,
                                         input logic [1:0] a);
    return (half & a[0]) | (word & (a != 2'b00));
  endfunction

  function automatic logic [LEN-1:0] extract_load(input logic [LEN-1:0] w,
                                                  input logic [1:0] a,
                                                  input logic lb, input logic lh,
                                                  input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    if (lb)      return uns ? {{(LEN-8){1'b0}}, b}  : {{(LEN-8){b[7]}}, b};
    else if (lh) return uns ? {{(LEN-16){1'b0}}, h} : {{(LEN-16){h[15]}}, h};
    else         return w;
  endfunction

  logic sb, sh, lb, lh, uns, bneq, branch, mem_read, mem_write;
  assign {sb, sh, lb, lh, uns, bneq, branch, mem_read, mem_write} = bus.i_ctrl_mem_bus;

  logic reg_write, mem_to_reg;
  assign {reg_write, mem_to_reg} = bus.i_ctrl_wb_bus;

  assign bus.o_pc_src        = branch & (bus.i_zero ^ bneq);
  assign bus.o_branch_target = bus.i_branch_target;

  logic [NB_DMEM_ADDR-1:0] idx;
  logic [1:0]              addr_lo;
  logic                    half, word, mis, we;
  assign idx     = bus.i_alu_result[NB_DMEM_ADDR+1:2];
  assign addr_lo = bus.i_alu_result[1:0];
  assign half    = sh | lh;
  assign word    = (mem_read | mem_write) & ~(half | sb | lb);
  assign mis     = is_misaligned(half, word, addr_lo);
  assign we      = mem_write & i_rst & ~mis;

  // Stores replicate the sub-word across lanes and pick lanes with a byte enable
  logic [NLANES-1:0] be;
  logic [LEN-1:0]    wdata;
  always_comb begin
    be    = '1;
    wdata = bus.i_store_data;
    if (sb) begin
      be    = '0;
      be[addr_lo] = 1'b1;
      wdata = {NLANES{bus.i_store_data[7:0]}};
    end else if (sh) begin
      be    = addr_lo[1] ? 4'b1100 : 4'b0011;
      wdata = {(NLANES/2){bus.i_store_data[15:0]}};
    end
  end

  // Zero at power-up; reset deliberately leaves the contents alone
  logic [LEN-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge i_clk) begin
    if (we)
      for (int l = 0; l < NLANES; l++)
        if (be[l]) mem[idx][8*l +: 8] <= wdata[8*l +: 8];
  end

  // ---- MEM/WB register (stage p1) ----
  logic [NB_ADDR-1:0] write_reg_p1;
  logic               reg_write_p1, mem_to_reg_p1;
  logic [LEN-1:0]     alu_result_p1, rd_word_p1;
  logic [1:0]         addr_lo_p1;
  logic               lb_p1, lh_p1, uns_p1, mis_p1;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      write_reg_p1  <= '0;
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      alu_result_p1 <= '0;
      rd_word_p1    <= '0;
      addr_lo_p1    <= '0;
      lb_p1         <= 1'b0;
      lh_p1         <= 1'b0;
      uns_p1        <= 1'b0;
      mis_p1        <= 1'b0;
    end else begin
      write_reg_p1  <= bus.i_write_reg;
      reg_write_p1  <= reg_write & ~(mis & mem_read);
      mem_to_reg_p1 <= mem_to_reg;
      alu_result_p1 <= bus.i_alu_result;
      rd_word_p1    <= mem[idx];
      addr_lo_p1    <= addr_lo;
      lb_p1         <= lb;
      lh_p1         <= lh;
      uns_p1        <= uns;
      mis_p1        <= mis;
    end
  end

  assign bus.o_write_reg  = write_reg_p1;
  assign bus.o_RegWrite   = reg_write_p1;
  assign bus.o_misaligned = mis_p1;
  assign bus.o_write_data = mem_to_reg_p1
                          ? extract_load(rd_word_p1, addr_lo_p1, lb_p1, lh_p1, uns_p1)
                          : alu_result_p1;

endmodule

// File: tb/tb_seg_memory_writeback.sv
// Directed test of the memory/writeback segment with hand-computed expectations.
module tb_seg_memory_writeback;

  localparam logic [8:0] C_NONE = 9'h000;
  localparam logic [8:0] C_SW   = 9'h001;
  localparam logic [8:0] C_LW   = 9'h002;
  localparam logic [8:0] C_RW   = 9'h003;
  localparam logic [8:0] C_SB   = 9'h101;
  localparam logic [8:0] C_SH   = 9'h081;
  localparam logic [8:0] C_LB   = 9'h042;
  localparam logic [8:0] C_LBU  = 9'h052;
  localparam logic [8:0] C_LH   = 9'h022;
  localparam logic [8:0] C_LHU  = 9'h032;
  localparam logic [8:0] C_BEQ  = 9'h004;
  localparam logic [8:0] C_BNE  = 9'h00C;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seg_memory_writeback_if #(.LEN(32), .NB_ADDR(5), .NB_CTRL_M(9), .NB_CTRL_WB(2)) bus ();

  seg_memory_writeback #(
    .LEN(32), .NB_ADDR(5), .NB_CTRL_M(9), .NB_CTRL_WB(2), .NB_DMEM_ADDR(10)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [8:0] ctrl, input logic [1:0] wb, input logic [31:0] addr,
                    input logic [31:0] sdata, input logic [4:0] wreg);
    bus.i_ctrl_mem_bus = ctrl;
    bus.i_ctrl_wb_bus  = wb;
    bus.i_alu_result   = addr;
    bus.i_store_data   = sdata;
    bus.i_write_reg    = wreg;
    tick();
  endtask

  initial begin
    bus.i_alu_result    = 32'h0000_1234;
    bus.i_store_data    = 32'h0;
    bus.i_write_reg     = 5'd5;
    bus.i_zero          = 1'b0;
    bus.i_branch_target = 32'h0000_0400;
    bus.i_ctrl_mem_bus  = C_LW;
    bus.i_ctrl_wb_bus   = 2'b11;

    // reset state, with a live load presented during reset
    rst = 1'b0;
    tick();
    check("rst_write_reg",  {27'b0, bus.o_write_reg}, 32'd0);
    check("rst_write_data", bus.o_write_data, 32'd0);
    check("rst_regwrite",   {31'b0, bus.o_RegWrite}, 32'd0);
    check("rst_misaligned", {31'b0, bus.o_misaligned}, 32'd0);
    rst = 1'b1;

    // word store then load
    op(C_SW, 2'b00, 32'h10, 32'hDEADBEEF, 5'd0);
    check("sw_regwrite", {31'b0, bus.o_RegWrite}, 32'd0);
    op(C_LW, 2'b11, 32'h10, 32'h0, 5'd8);
    check("lw_data",     bus.o_write_data, 32'hDEADBEEF);
    check("lw_reg",      {27'b0, bus.o_write_reg}, 32'd8);
    check("lw_regwrite", {31'b0, bus.o_RegWrite}, 32'd1);
    check("lw_mis",      {31'b0, bus.o_misaligned}, 32'd0);

    // byte store into lane 3 and byte/word loads
    op(C_SB, 2'b00, 32'h13, 32'h0000_0080, 5'd0);
    op(C_LB, 2'b11, 32'h13, 32'h0, 5'd9);
    check("lb_signed", bus.o_write_data, 32'hFFFFFF80);
    op(C_LBU, 2'b11, 32'h13, 32'h0, 5'd9);
    check("lb_unsigned", bus.o_write_data, 32'h00000080);
    op(C_LW, 2'b11, 32'h10, 32'h0, 5'd9);
    check("lw_after_sb", bus.o_write_data, 32'h80ADBEEF);

    // halfword store into upper half, aligned and misaligned loads
    op(C_SH, 2'b00, 32'h22, 32'hABCD1234, 5'd0);
    op(C_LH, 2'b11, 32'h22, 32'h0, 5'd10);
    check("lh_data", bus.o_write_data, 32'h00001234);
    op(C_LW, 2'b11, 32'h20, 32'h0, 5'd10);
    check("lw_after_sh", bus.o_write_data, 32'h12340000);
    op(C_LH, 2'b11, 32'h21, 32'h0, 5'd3);
    check("lh_mis_pulse",    {31'b0, bus.o_misaligned}, 32'd1);
    check("lh_mis_regwrite", {31'b0, bus.o_RegWrite}, 32'd0);
    op(C_NONE, 2'b00, 32'h0, 32'h0, 5'd0);
    check("lh_mis_end", {31'b0, bus.o_misaligned}, 32'd0);

    // signed/unsigned halfword and lane-1 byte
    op(C_SH, 2'b00, 32'h30, 32'h0000_8001, 5'd0);
    op(C_LH, 2'b11, 32'h30, 32'h0, 5'd11);
    check("lh_signed", bus.o_write_data, 32'hFFFF8001);
    op(C_LHU, 2'b11, 32'h30, 32'h0, 5'd11);
    check("lh_unsigned", bus.o_write_data, 32'h00008001);
    op(C_LB, 2'b11, 32'h31, 32'h0, 5'd11);
    check("lb_lane1", bus.o_write_data, 32'hFFFFFF80);
    op(C_LBU, 2'b11, 32'h30, 32'h0, 5'd11);
    check("lbu_lane0", bus.o_write_data, 32'h00000001);

    // misaligned word store must not write memory
    op(C_SW, 2'b00, 32'h41, 32'h5555_5555, 5'd0);
    check("sw_mis_pulse", {31'b0, bus.o_misaligned}, 32'd1);
    op(C_LW, 2'b11, 32'h40, 32'h0, 5'd12);
    check("sw_mis_nowrite", bus.o_write_data, 32'h0);

    // branch decision (combinational) and target pass-through
    bus.i_ctrl_mem_bus = C_BEQ; bus.i_zero = 1'b1; #1;
    check("beq_taken", {31'b0, bus.o_pc_src}, 32'd1);
    bus.i_ctrl_mem_bus = C_BNE; bus.i_zero = 1'b1; #1;
    check("bne_not_taken", {31'b0, bus.o_pc_src}, 32'd0);
    bus.i_ctrl_mem_bus = C_BNE; bus.i_zero = 1'b0; #1;
    check("bne_taken", {31'b0, bus.o_pc_src}, 32'd1);
    bus.i_ctrl_mem_bus = C_NONE; bus.i_zero = 1'b1; #1;
    check("no_branch", {31'b0, bus.o_pc_src}, 32'd0);
    bus.i_branch_target = 32'h0BAD_F00D; #1;
    check("branch_target", bus.o_branch_target, 32'h0BADF00D);

    // reset mid-load discards the result and suppresses a concurrent store
    op(C_LW, 2'b11, 32'h10, 32'h0, 5'd8);
    check("pre_rst_regwrite", {31'b0, bus.o_RegWrite}, 32'd1);
    rst = 1'b0;
    op(C_SW, 2'b11, 32'h40, 32'hFFFFFFFF, 5'd7);
    check("rst_mid_regwrite", {31'b0, bus.o_RegWrite}, 32'd0);
    check("rst_mid_data",     bus.o_write_data, 32'h0);
    check("rst_mid_reg",      {27'b0, bus.o_write_reg}, 32'd0);
    rst = 1'b1;
    op(C_LW, 2'b11, 32'h40, 32'h0, 5'd7);
    check("rst_store_suppressed", bus.o_write_data, 32'h0);

    // address wrap
    op(C_SW, 2'b00, 32'h1000, 32'hA5A5A5A5, 5'd0);
    op(C_LW, 2'b11, 32'h0, 32'h0, 5'd13);
    check("addr_wrap", bus.o_write_data, 32'hA5A5A5A5);

    // simultaneous read/write returns pre-write word, write still lands
    op(C_RW, 2'b11, 32'h0, 32'h11111111, 5'd14);
    check("rw_prewrite", bus.o_write_data, 32'hA5A5A5A5);
    op(C_LW, 2'b11, 32'h0, 32'h0, 5'd14);
    check("rw_written", bus.o_write_data, 32'h11111111);

    // bubble and ALU-result writeback
    op(C_NONE, 2'b00, 32'h0, 32'h0, 5'd0);
    check("bubble_regwrite", {31'b0, bus.o_RegWrite}, 32'd0);
    op(C_NONE, 2'b10, 32'hCAFEF00D, 32'h0, 5'd15);
    check("alu_data",     bus.o_write_data, 32'hCAFEF00D);
    check("alu_regwrite", {31'b0, bus.o_RegWrite}, 32'd1);
    check("alu_reg",      {27'b0, bus.o_write_reg}, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
